// File: rtl/icache_data_bank_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// icache_data_bank_ctrl_pkg
// Shared widths and payload types for the I-cache data-array controller.
//   icache_linefill_t  : linefill return payload {data, txnid, entry_idx, index, way}
//   icache_data_resp_t : upstream data response {txnid, data}
// -----------------------------------------------------------------------------
package icache_data_bank_ctrl_pkg;

    localparam int ICACHE_LINE_WIDTH      = 512;
    localparam int ICACHE_DATA_BANK_NUM   = 2;
    localparam int ICACHE_WAY_NUM         = 4;
    localparam int ICACHE_INDEX_WIDTH     = 6;
    localparam int ICACHE_REQ_TXNID_WIDTH = 4;
    localparam int MSHR_ENTRY_INDEX_WIDTH = 2;
    localparam int ICACHE_RESP_FIFO_DEPTH = 4;

    // A single-way cache still needs a one-bit way field in the RAM address.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ICACHE_WAY_WIDTH = clog2_min1(ICACHE_WAY_NUM);

    typedef struct packed {
        logic [ICACHE_LINE_WIDTH-1:0]      data;
        logic [ICACHE_REQ_TXNID_WIDTH-1:0] txnid;
        logic [MSHR_ENTRY_INDEX_WIDTH-1:0] entry_idx;
        logic [ICACHE_INDEX_WIDTH-1:0]     index;
        logic [ICACHE_WAY_WIDTH-1:0]       way;
    } icache_linefill_t;

    typedef struct packed {
        logic [ICACHE_REQ_TXNID_WIDTH-1:0] txnid;
        logic [ICACHE_LINE_WIDTH-1:0]      data;
    } icache_data_resp_t;

endpackage

// File: rtl/icache_data_bank_ctrl_resp_fifo.sv
// -----------------------------------------------------------------------------
// icache_resp_fifo
// Generic synchronous FIFO holding upstream responses. The writer guarantees
// it never pushes when full and the reader never pops when empty.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data this cycle
//   push_data   : entry to write
//   pop         : drop the head entry this cycle
//   count       : occupancy 0..DEPTH
//   empty       : count == 0
//   head        : oldest entry (meaningful only when !empty)
// -----------------------------------------------------------------------------
module icache_resp_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output T                       head
);

    localparam int PTR_W = $clog2(DEPTH);

    T                 mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Power-of-two depth: pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/icache_data_bank_ctrl.sv
// -----------------------------------------------------------------------------
// icache_data_bank_ctrl
// I-cache data-array controller: one RAM op per cycle (linefill write has
// priority over hit read). Read data, and linefill data when bypass is built
// in, return upstream through a one-stage register and a credit-checked FIFO.
// Build option:
//   ICACHE_LINEFILL_BYPASS_EN : linefills also return their line upstream and
//                               are gated by response credit.
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   dataram_rd_vld/rdy, _index/_way/_txnid : hit-read request
//   downstream_rxdat_vld/rdy, _pld     : linefill return
//   linefill_done, linefill_ack_entry_idx : linefill accepted this cycle
//   upstream_txdat_vld/rdy, _data/_txnid  : response to upstream
//   data_ram_en, data_array_wr_en, data_array_addr, data_array_din,
//   data_array_dout                    : banked data SRAM interface
// -----------------------------------------------------------------------------
module icache_data_bank_ctrl
    import icache_data_bank_ctrl_pkg::*;
#(
    parameter  int LINE_W     = ICACHE_LINE_WIDTH,
    parameter  int NUM_BANKS  = ICACHE_DATA_BANK_NUM,
    parameter  int NUM_WAYS   = ICACHE_WAY_NUM,
    parameter  int INDEX_W    = ICACHE_INDEX_WIDTH,
    parameter  int TXNID_W    = ICACHE_REQ_TXNID_WIDTH,
    parameter  int ENTRY_W    = MSHR_ENTRY_INDEX_WIDTH,
    parameter  int RESP_DEPTH = ICACHE_RESP_FIFO_DEPTH,
    localparam int WAY_W      = clog2_min1(NUM_WAYS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     dataram_rd_vld,
    output logic                     dataram_rd_rdy,
    input  logic [INDEX_W-1:0]       dataram_rd_index,
    input  logic [WAY_W-1:0]         dataram_rd_way,
    input  logic [TXNID_W-1:0]       dataram_rd_txnid,
    input  logic                     downstream_rxdat_vld,
    output logic                     downstream_rxdat_rdy,
    input  icache_linefill_t         downstream_rxdat_pld,
    output logic                     linefill_done,
    output logic [ENTRY_W-1:0]       linefill_ack_entry_idx,
    output logic                     upstream_txdat_vld,
    input  logic                     upstream_txdat_rdy,
    output logic [LINE_W-1:0]        upstream_txdat_data,
    output logic [TXNID_W-1:0]       upstream_txdat_txnid,
    output logic                     data_ram_en,
    output logic                     data_array_wr_en,
    output logic [INDEX_W+WAY_W-1:0] data_array_addr,
    output logic [LINE_W-1:0]        data_array_din,
    input  logic [LINE_W-1:0]        data_array_dout
);

    localparam int BANK_W = LINE_W / NUM_BANKS;
    localparam int CNT_W  = $clog2(RESP_DEPTH) + 1;

    logic              credit_ok;
    logic [CNT_W-1:0]  occupancy;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_empty;
    logic              fifo_pop;
    icache_data_resp_t fifo_head;
    icache_data_resp_t fifo_push_data;

    logic              lf_acc;
    logic              lf_resp;
    logic              rd_acc;

    logic              s1_vld;
    logic              s1_rd;
    logic [TXNID_W-1:0] s1_txnid;
    logic [LINE_W-1:0] s1_data;

    // Occupancy counts the op sitting in stage 1 as already holding a slot;
    // the same-cycle pop is deliberately ignored so no rdy sees upstream rdy.
    assign occupancy = fifo_count + CNT_W'(s1_vld);
    assign credit_ok = (occupancy < CNT_W'(RESP_DEPTH));

`ifdef ICACHE_LINEFILL_BYPASS_EN
    assign downstream_rxdat_rdy = rst_n && credit_ok;
    assign lf_resp              = lf_acc;
`else
    logic lf_txnid_unused;
    assign downstream_rxdat_rdy = rst_n;
    assign lf_resp              = 1'b0;
    assign lf_txnid_unused      = ^downstream_rxdat_pld.txnid;
`endif

    assign dataram_rd_rdy = rst_n && !downstream_rxdat_vld && credit_ok;

    assign lf_acc = downstream_rxdat_vld && downstream_rxdat_rdy;
    assign rd_acc = dataram_rd_vld && dataram_rd_rdy;

    assign linefill_done          = lf_acc;
    assign linefill_ack_entry_idx = downstream_rxdat_pld.entry_idx;

    assign data_ram_en      = lf_acc || rd_acc;
    assign data_array_wr_en = lf_acc;
    assign data_array_addr  = lf_acc ? {downstream_rxdat_pld.index, downstream_rxdat_pld.way}
                                     : {dataram_rd_index, dataram_rd_way};

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        assign data_array_din[b*BANK_W +: BANK_W] = downstream_rxdat_pld.data[b*BANK_W +: BANK_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_rd    <= 1'b0;
            s1_txnid <= '0;
            s1_data  <= '0;
        end else begin
            s1_vld <= lf_resp || rd_acc;
            if (lf_resp || rd_acc) begin
                s1_rd    <= rd_acc;
                s1_txnid <= rd_acc ? dataram_rd_txnid : downstream_rxdat_pld.txnid;
            end
            if (lf_resp) s1_data <= downstream_rxdat_pld.data;
        end
    end

    // Reads take the SRAM output that arrives one cycle after the access.
    assign fifo_push_data.txnid = s1_txnid;
    assign fifo_push_data.data  = s1_rd ? data_array_dout : s1_data;
    assign fifo_pop             = upstream_txdat_vld && upstream_txdat_rdy;

    icache_resp_fifo #(
        .DEPTH (RESP_DEPTH),
        .T     (icache_data_resp_t)
    ) u_resp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (s1_vld),
        .push_data (fifo_push_data),
        .pop       (fifo_pop),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    // Storage is not reset; mask the head so an empty FIFO presents zeros.
    assign upstream_txdat_vld   = !fifo_empty;
    assign upstream_txdat_data  = fifo_empty ? '0 : fifo_head.data;
    assign upstream_txdat_txnid = fifo_empty ? '0 : fifo_head.txnid;

endmodule

// File: tb/tb_icache_data_bank_ctrl.sv
module tb_icache_data_bank_ctrl;
    import icache_data_bank_ctrl_pkg::*;

    localparam int LINE_W  = ICACHE_LINE_WIDTH;
    localparam int INDEX_W = ICACHE_INDEX_WIDTH;
    localparam int WAY_W   = ICACHE_WAY_WIDTH;
    localparam int TXNID_W = ICACHE_REQ_TXNID_WIDTH;
    localparam int ENTRY_W = MSHR_ENTRY_INDEX_WIDTH;
    localparam int DEPTH   = ICACHE_RESP_FIFO_DEPTH;
    localparam int ADDR_W  = INDEX_W + WAY_W;
`ifdef ICACHE_LINEFILL_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                clk;
    logic                rst_n;
    logic                dataram_rd_vld;
    logic                dataram_rd_rdy;
    logic [INDEX_W-1:0]  dataram_rd_index;
    logic [WAY_W-1:0]    dataram_rd_way;
    logic [TXNID_W-1:0]  dataram_rd_txnid;
    logic                downstream_rxdat_vld;
    logic                downstream_rxdat_rdy;
    icache_linefill_t    downstream_rxdat_pld;
    logic                linefill_done;
    logic [ENTRY_W-1:0]  linefill_ack_entry_idx;
    logic                upstream_txdat_vld;
    logic                upstream_txdat_rdy;
    logic [LINE_W-1:0]   upstream_txdat_data;
    logic [TXNID_W-1:0]  upstream_txdat_txnid;
    logic                data_ram_en;
    logic                data_array_wr_en;
    logic [ADDR_W-1:0]   data_array_addr;
    logic [LINE_W-1:0]   data_array_din;
    logic [LINE_W-1:0]   data_array_dout;

    icache_data_bank_ctrl dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .dataram_rd_vld         (dataram_rd_vld),
        .dataram_rd_rdy         (dataram_rd_rdy),
        .dataram_rd_index       (dataram_rd_index),
        .dataram_rd_way         (dataram_rd_way),
        .dataram_rd_txnid       (dataram_rd_txnid),
        .downstream_rxdat_vld   (downstream_rxdat_vld),
        .downstream_rxdat_rdy   (downstream_rxdat_rdy),
        .downstream_rxdat_pld   (downstream_rxdat_pld),
        .linefill_done          (linefill_done),
        .linefill_ack_entry_idx (linefill_ack_entry_idx),
        .upstream_txdat_vld     (upstream_txdat_vld),
        .upstream_txdat_rdy     (upstream_txdat_rdy),
        .upstream_txdat_data    (upstream_txdat_data),
        .upstream_txdat_txnid   (upstream_txdat_txnid),
        .data_ram_en            (data_ram_en),
        .data_array_wr_en       (data_array_wr_en),
        .data_array_addr        (data_array_addr),
        .data_array_din         (data_array_din),
        .data_array_dout        (data_array_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected response: what upstream must see and the first cycle it may appear.
    typedef struct {
        logic [TXNID_W-1:0] txnid;
        logic [LINE_W-1:0]  data;
        int                 due;
    } exp_t;

    exp_t              exp_q[$];
    logic [LINE_W-1:0] ref_mem [2**ADDR_W];
    logic [LINE_W-1:0] ram     [2**ADDR_W];
    int                n_tests;
    int                n_fail;
    int                cyc;

    task automatic check_val(input string tag, input logic [LINE_W-1:0] obs,
                             input logic [LINE_W-1:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h want %0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] r;
        for (int i = 0; i < LINE_W/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic rand_payload();
        downstream_rxdat_pld.data      = rand_line();
        downstream_rxdat_pld.txnid     = TXNID_W'($urandom);
        downstream_rxdat_pld.entry_idx = ENTRY_W'($urandom);
        downstream_rxdat_pld.index     = INDEX_W'($urandom);
        downstream_rxdat_pld.way       = WAY_W'($urandom);
        dataram_rd_index               = INDEX_W'($urandom);
        dataram_rd_way                 = WAY_W'($urandom);
        dataram_rd_txnid               = TXNID_W'($urandom);
    endtask

    // One cycle: drive after the edge, check mid-cycle, advance model at the edge,
    // then play the SRAM (write, or read data valid the following cycle).
    task automatic step(input bit lf_v, input bit rd_v, input bit up_r, input bit rst_val);
        bit                exp_lf_rdy, exp_rd_rdy, lf_acc, rd_acc, exp_vld;
        logic [ADDR_W-1:0] lf_addr, rd_addr, pre_addr;
        logic              pre_en, pre_wr;
        logic [LINE_W-1:0] pre_din;
        int                t;

        rst_n                = rst_val;
        downstream_rxdat_vld = lf_v;
        dataram_rd_vld       = rd_v;
        upstream_txdat_rdy   = up_r;
        #2;
        if (!rst_val) exp_q.delete();
        lf_addr    = {downstream_rxdat_pld.index, downstream_rxdat_pld.way};
        rd_addr    = {dataram_rd_index, dataram_rd_way};
        exp_lf_rdy = rst_val && (!BYPASS || exp_q.size() < DEPTH);
        exp_rd_rdy = rst_val && !lf_v && (exp_q.size() < DEPTH);
        lf_acc     = lf_v && exp_lf_rdy;
        rd_acc     = rd_v && exp_rd_rdy;
        exp_vld    = (exp_q.size() > 0) && (exp_q[0].due <= cyc);

        check_val("rd_rdy",  dataram_rd_rdy,       exp_rd_rdy);
        check_val("lf_rdy",  downstream_rxdat_rdy, exp_lf_rdy);
        check_val("lf_done", linefill_done,        lf_acc);
        check_val("ram_en",  data_ram_en,          lf_acc || rd_acc);
        check_val("wr_en",   data_array_wr_en,     lf_acc);
        check_val("up_vld",  upstream_txdat_vld,   exp_vld);
        if (lf_acc) begin
            check_val("ack_entry", linefill_ack_entry_idx, downstream_rxdat_pld.entry_idx);
            check_val("wr_addr",   data_array_addr,        lf_addr);
            check_val("wr_din",    data_array_din,         downstream_rxdat_pld.data);
        end else if (rd_acc) begin
            check_val("rd_addr",   data_array_addr,        rd_addr);
        end
        if (exp_vld) begin
            check_val("resp_data",  upstream_txdat_data,  exp_q[0].data);
            check_val("resp_txnid", upstream_txdat_txnid, exp_q[0].txnid);
        end else if (!rst_val) begin
            check_val("rst_data",  upstream_txdat_data,  '0);
            check_val("rst_txnid", upstream_txdat_txnid, '0);
        end

        pre_en   = data_ram_en;
        pre_wr   = data_array_wr_en;
        pre_addr = data_array_addr;
        pre_din  = data_array_din;

        @(posedge clk);
        t = cyc;
        cyc++;
        if (exp_vld && up_r) void'(exp_q.pop_front());
        if (rd_acc) exp_q.push_back('{txnid: dataram_rd_txnid, data: ref_mem[rd_addr], due: t + 2});
        if (lf_acc) begin
            if (BYPASS)
                exp_q.push_back('{txnid: downstream_rxdat_pld.txnid,
                                  data: downstream_rxdat_pld.data, due: t + 2});
            ref_mem[lf_addr] = downstream_rxdat_pld.data;
        end
        #1;
        if (pre_en) begin
            if (pre_wr) ram[pre_addr] = pre_din;
            else        data_array_dout = ram[pre_addr];
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        data_array_dout = '0;
        for (int i = 0; i < 2**ADDR_W; i++) begin
            ref_mem[i] = rand_line();
            ram[i]     = ref_mem[i];
        end
        rst_n = 1'b0;
        rand_payload();
        downstream_rxdat_vld = 1'b0;
        dataram_rd_vld       = 1'b0;
        upstream_txdat_rdy   = 1'b0;
        #1;

        // Reset: requests present but nothing may be accepted.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0);

        // Single read idx 5 way 2 txnid 3, response two cycles later.
        rand_payload();
        dataram_rd_index = 5; dataram_rd_way = 2; dataram_rd_txnid = 3;
        step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1);

        // Linefill and read collide: linefill wins, read goes next cycle.
        rand_payload();
        downstream_rxdat_pld.index = 7; downstream_rxdat_pld.way = 1;
        downstream_rxdat_pld.txnid = 9; downstream_rxdat_pld.entry_idx = 2;
        dataram_rd_index = 7; dataram_rd_way = 1;
        step(1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1);

        // Upstream stalled: credit caps accepted reads; then a linefill while full.
        for (int i = 0; i < 6; i++) begin
            rand_payload();
            step(1'b0, 1'b1, 1'b0, 1'b1);
        end
        rand_payload();
        step(1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b1, 1'b1);

        // Random traffic with random upstream back-pressure.
        for (int i = 0; i < 300; i++) begin
            rand_payload();
            step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 3) != 0), 1'b1);
        end

        // Reset with responses queued and stage 1 busy; nothing may follow.
        for (int i = 0; i < 3; i++) begin
            rand_payload();
            step(1'b0, 1'b1, 1'b0, 1'b1);
        end
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 1'b1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
